btn_debounce_irq: RTL and testbench
===================================

// Module: btn_debounce_irq
// PURPOSE
//  Wishbone slave peripheral on the MCU's Alice bus, beside demo_io.
//  Synchronises and debounces the board button inputs, latches rise/fall events
//  in sticky flags, and drives a level interrupt into one bit of the MCU irqs input.
//  Replaces polling of raw gp_i bits by firmware.
// PARAMETERS
//  WIDTH     2     number of button inputs, 1..16
//  PRESCALE  1000  clk cycles per debounce sample tick, >=2
//  STABLE    8     consecutive differing ticks needed to accept a change, 1..255
// PORTS
//  clk    in   1      system clock
//  rst_n  in   1      reset; asynchronous, active-low
//  adr_i  in   15     word address; only adr_i[1:0] decoded, upper bits ignored
//  dat_i  in   32     write data
//  dat_o  out  32     read data, valid when ack_o=1
//  we_i   in   1      1=write, 0=read
//  stb_i  in   1      strobe, held by master until ack_o
//  ack_o  out  1      single-cycle acknowledge
//  btn_i  in   WIDTH  raw asynchronous button inputs, active-high
//  irq_o  out  1      level interrupt, registered
// BEHAVIOUR
//  Reset: dat_o=0, ack_o=0, irq_o=0; sync flops, state, events, mask, counters all 0.
//  Bus:
//   - Access fires on the edge where stb_i=1 and ack_o=0.
//   - ack_o=1 on the following cycle only, then returns to 0.
//   - A held stb_i therefore re-fires every 2nd cycle; master drops stb_i on ack_o.
//   - Read data registered at the firing edge; zero-extended.
//  Register map, adr_i[1:0]:
//   0 STATE  RO   [WIDTH-1:0]=debounced state; writes ignored.
//   1 EVENT  W1C  [WIDTH-1:0]=rise flags; [WIDTH+15:16]=fall flags.
//   2 MASK   RW   same bit layout as EVENT; unused bits read 0.
//   3 INFO   RO   [7:0]=WIDTH, [15:8]=STABLE.
//  Input path:
//   - 2-flop synchroniser per bit.
//   - Prescaler counts 0..PRESCALE-1; tick is 1 clk wide at the terminal count, then wraps.
//  Per bit, evaluated on tick only, 8-bit counter cnt:
//   - Sample == state: cnt<=0.
//   - Sample != state and cnt==STABLE-1: state<=sample, cnt<=0, set rise (0->1) or fall (1->0) flag.
//   - Otherwise: cnt<=cnt+1.
//   - Net latency from a clean input step to state change:
//     2 sync clks + STABLE ticks, with +-1 tick phase uncertainty.
//  Event flags:
//   - Sticky until written 1 at EVENT.
//   - Set and W1C clear on the same edge: set wins.
//  irq_o <= |(EVENT & MASK), one clk after the flag or mask update.
//  Bounce: any tick where the sample matches state restarts cnt. No event fires unless
//   STABLE consecutive ticks differ.
//  Reset mid-operation: async clear of everything; a pressed button at release of reset
//   produces a rise event after the debounce latency.
// TESTING
//  1 Reset, PRESCALE=4 STABLE=3, btn_i=2'b00 -> STATE=0, EVENT=0, irq_o=0, INFO=0x0302.
//  2 btn_i[0]=1 held -> STATE=1 after 2+12(+-4) clks; EVENT=0x00001; irq_o stays 0 (MASK=0).
//  3 Write MASK=0x1, then irq_o=1 one clk later.
//    Write EVENT=0x1 -> irq_o=0 one clk later; EVENT reads 0.
//  4 Toggle btn_i[1] each 6 clks for 100 clks -> no change to STATE/EVENT;
//    then hold 0 from 1 -> fall flag bit 17 set.
//  5 Rise event lands on the same edge as an EVENT W1C of bit 0 -> bit 0 remains 1.
//  6 stb_i held 5 clks on a read -> ack_o pattern 0,1,0,1,0; dat_o valid at each ack.
//    Assert rst_n=0 mid-debounce -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/btn_debounce_irq.sv
// Button synchroniser/debouncer with sticky rise/fall flags and a masked level interrupt on a Wishbone slave.
// Bus: one-cycle ack after the firing edge, no wait states; state change lands 2 clks + STABLE ticks after a clean input step.
module btn_debounce_irq #(
  parameter int WIDTH    = 2,
  parameter int PRESCALE = 1000,
  parameter int STABLE   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  input  logic             we_i,
  input  logic             stb_i,
  output logic             ack_o,
  input  logic [WIDTH-1:0] btn_i,
  output logic             irq_o
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      CNT_LAST = 8'(STABLE - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_state;
  logic [WIDTH-1:0] r_rise, r_fall, r_mrise, r_mfall;
  logic [7:0]       r_cnt [WIDTH];
  logic [PW-1:0]    r_presc;
  logic [31:0]      r_dat;
  logic             r_ack, r_irq;

  logic             w_tick, w_fire, w_wr_evt, w_wr_mask, w_unused;
  logic [WIDTH-1:0] w_accept, w_set_rise, w_set_fall, w_clr_rise, w_clr_fall;
  logic [31:0]      w_rd_dat;

  assign w_tick    = (r_presc == PRE_LAST);
  assign w_fire    = stb_i & ~r_ack;
  assign w_wr_evt  = w_fire & we_i & (adr_i[1:0] == 2'd1);
  assign w_wr_mask = w_fire & we_i & (adr_i[1:0] == 2'd2);
  assign w_unused  = ^{adr_i[14:2], dat_i};

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_tick & (r_sync2[i] != r_state[i]) & (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_set_rise = w_accept & r_sync2;
  assign w_set_fall = w_accept & ~r_sync2;
  assign w_clr_rise = w_wr_evt ? dat_i[WIDTH-1:0]     : '0;
  assign w_clr_fall = w_wr_evt ? dat_i[WIDTH+15:16]   : '0;

  always_comb begin
    w_rd_dat = '0;
    case (adr_i[1:0])
      2'd0: w_rd_dat[WIDTH-1:0] = r_state;
      2'd1: begin
        w_rd_dat[WIDTH-1:0]   = r_rise;
        w_rd_dat[WIDTH+15:16] = r_fall;
      end
      2'd2: begin
        w_rd_dat[WIDTH-1:0]   = r_mrise;
        w_rd_dat[WIDTH+15:16] = r_mfall;
      end
      default: begin
        w_rd_dat[7:0]  = 8'(WIDTH);
        w_rd_dat[15:8] = 8'(STABLE);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_presc <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // Any tick whose sample agrees with the accepted state restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_state[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise  <= '0;
      r_fall  <= '0;
      r_mrise <= '0;
      r_mfall <= '0;
      r_irq   <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      // A new event outranks a simultaneous write-1-to-clear.
      r_rise <= (r_rise & ~w_clr_rise) | w_set_rise;
      r_fall <= (r_fall & ~w_clr_fall) | w_set_fall;
      if (w_wr_mask) begin
        r_mrise <= dat_i[WIDTH-1:0];
        r_mfall <= dat_i[WIDTH+15:16];
      end
      r_irq <= |((r_rise & r_mrise) | (r_fall & r_mfall));
      r_ack <= w_fire;
      if (w_fire && !we_i) r_dat <= w_rd_dat;
    end
  end

  assign dat_o = r_dat;
  assign ack_o = r_ack;
  assign irq_o = r_irq;

endmodule

// File: tb/tb_btn_debounce_irq.sv
// Randomised bench for btn_debounce_irq: event-level reference model feeds a read-data queue checked by a monitor.
module tb_btn_debounce_irq;
  localparam int W = 2;
  localparam int P = 4;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [14:0]   adr_i = '0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic          we_i = 1'b0;
  logic          stb_i = 1'b0;
  logic          ack_o;
  logic [W-1:0]  btn_i = '0;
  logic          irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_debounce_irq #(.WIDTH(W), .PRESCALE(P), .STABLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .btn_i(btn_i), .irq_o(irq_o)
  );

  typedef struct packed { logic rd; logic [31:0] d; } exp_t;
  exp_t exp_q[$];

  // Reference model: clock count, input history, per-button run of disagreeing ticks.
  int           m_n;
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_state, m_rise, m_fall, m_mrise, m_mfall;
  logic         m_ack = 1'b0, m_irq = 1'b0;
  int           m_run [W];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[W-1:0] = m_state;
      2'd1: begin r[W-1:0] = m_rise;  r[W+15:16] = m_fall;  end
      2'd2: begin r[W-1:0] = m_mrise; r[W+15:16] = m_mfall; end
      default: r = (32'(S) << 8) | 32'(W);
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_n = 0;
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
    m_state = '0; m_rise = '0; m_fall = '0; m_mrise = '0; m_mfall = '0;
    m_ack = 1'b0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    exp_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [W-1:0] smp, set_r, set_f, clr_r, clr_f;
    logic         tick, fire;
    exp_t         e;
    if (!rst_n) begin
      m_reset();
    end else begin
      smp = m_hist.pop_front();
      m_hist.push_back(btn_i);
      tick = ((m_n % P) == P - 1);
      m_n++;
      m_irq = |((m_rise & m_mrise) | (m_fall & m_mfall));
      fire = stb_i && !m_ack;
      m_ack = fire;
      if (fire) begin
        e.rd = !we_i;
        e.d  = m_read(adr_i[1:0]);
        exp_q.push_back(e);
      end
      clr_r = '0; clr_f = '0; set_r = '0; set_f = '0;
      if (fire && we_i && adr_i[1:0] == 2'd1) begin
        clr_r = dat_i[W-1:0];
        clr_f = dat_i[W+15:16];
      end
      if (tick) begin
        for (int i = 0; i < W; i++) begin
          if (smp[i] == m_state[i]) begin
            m_run[i] = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] == S) begin
              m_state[i] = smp[i];
              m_run[i] = 0;
              if (smp[i]) set_r[i] = 1'b1; else set_f[i] = 1'b1;
            end
          end
        end
      end
      m_rise = (m_rise & ~clr_r) | set_r;
      m_fall = (m_fall & ~clr_f) | set_f;
      if (fire && we_i && adr_i[1:0] == 2'd2) begin
        m_mrise = dat_i[W-1:0];
        m_mfall = dat_i[W+15:16];
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      chk("ack", {31'd0, ack_o}, {31'd0, m_ack});
      chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
      if (ack_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack at %0t: ack=1 expected no transaction", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.rd) chk("rdata", dat_o, e.d);
        end
      end
    end
  end

  task automatic wait_clk(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d);
    int k;
    @(negedge clk);
    stb_i = 1'b1; we_i = we; adr_i = {13'($urandom), a}; dat_i = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack_o && k < 4);
    if (!ack_o) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_ack_timeout at %0t: ack=0 expected 1 within 4 clks", $time);
    end
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wait_clk(3);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    #1 rst_n = 1'b1;

    bus(0, 2'd0, 0); bus(0, 2'd1, 0); bus(0, 2'd3, 0); bus(0, 2'd2, 0);

    btn_i = 2'b01;
    wait_clk(30);
    bus(0, 2'd0, 0); bus(0, 2'd1, 0);
    bus(1, 2'd2, 32'h1); wait_clk(3);
    bus(1, 2'd1, 32'h1); wait_clk(3);
    bus(0, 2'd1, 0);

    for (int i = 0; i < 16; i++) begin
      btn_i[1] = ~btn_i[1];
      wait_clk(6);
    end
    bus(0, 2'd0, 0); bus(0, 2'd1, 0);
    bus(1, 2'd2, 32'h0003_0003);
    btn_i[1] = 1'b1; wait_clk(30);
    btn_i[1] = 1'b0; wait_clk(30);
    bus(0, 2'd1, 0); bus(0, 2'd0, 0);

    // Sweep the clear point across the debounce window so one write coincides with the rise.
    for (int off = 6; off <= 22; off++) begin
      btn_i[0] = 1'b0; wait_clk(25);
      bus(1, 2'd1, 32'hFFFF_FFFF); wait_clk(2);
      btn_i[0] = 1'b1; wait_clk(off);
      bus(1, 2'd1, 32'h1);
      bus(0, 2'd1, 0);
    end

    @(negedge clk);
    stb_i = 1'b1; we_i = 1'b0; adr_i = 15'd3;
    wait_clk(5);
    stb_i = 1'b0;
    wait_clk(2);

    repeat (60) begin
      if ($urandom_range(0, 2) == 0) btn_i = W'($urandom);
      wait_clk(int'($urandom_range(0, 15)));
      case (int'($urandom_range(0, 3)))
        0: bus(0, 2'($urandom), 0);
        1: bus(1, 2'd2, $urandom);
        2: bus(1, 2'd1, $urandom);
        default: bus(1, 2'd0, $urandom);
      endcase
    end

    btn_i = 2'b00; wait_clk(30);
    bus(1, 2'd2, 32'h0003_0003);
    btn_i = 2'b11; wait_clk(30);
    bus(0, 2'd3, 0);
    btn_i = 2'b00; wait_clk(7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dat", dat_o, 32'd0);
    chk("arst_ack", {31'd0, ack_o}, 32'd0);
    chk("arst_irq", {31'd0, irq_o}, 32'd0);
    btn_i = 2'b01;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_clk(30);
    bus(0, 2'd1, 0); bus(0, 2'd0, 0); bus(0, 2'd2, 0);
    wait_clk(3);

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover_expect: %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
